// File: rtl/rgmii_rx_nibble_framer_pkg.sv
// Shared definitions for the RGMII 10/100 receive nibble framer and its siblings.
package rgmii_rx_nibble_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0] SFD_NIBBLE      = 4'hD;

  localparam int ALIGN_LEGACY = 0;
  localparam int ALIGN_SFD    = 1;

  // Ethernet sends the low nibble first; swap covers PHYs that do the opposite.
  function automatic logic [7:0] pair_nibbles(input logic [3:0] first,
                                              input logic [3:0] second,
                                              input logic       swap);
    return swap ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/eth_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES clock edges.
module eth_rst_sync #(
  parameter int STAGES = 3
) (
  input  logic clk_i,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/rgmii_rx_nibble_framer.sv
// RGMII 10/100 receive front end: pairs sampled nibbles into bytes, optionally
// hunting the SFD, and reports frame boundaries, length and error.
module rgmii_rx_nibble_framer
  import rgmii_rx_nibble_framer_pkg::*;
#(
  parameter int ALIGN_MODE      = 1,
  parameter int NIBBLE_SWAP     = 0,
  parameter int MAX_PRE_NIBBLES = 16,
  parameter int LEN_W           = 16,
  parameter int RST_STAGES      = 3
) (
  input  logic             eth_rxc_sample,
  input  logic             rst_n,
  input  logic             rx_ce,
  input  logic             rgmii_rx_ctl,
  input  logic [3:0]       rgmii_rxd,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_vld,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_sof,
  output logic             gmii_rx_eof,
  output logic             gmii_rx_err,
  output logic [LEN_W-1:0] frame_len
);

  localparam int PRE_W = $clog2(MAX_PRE_NIBBLES + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MAX_PRE_NIBBLES);

  logic rst_int_n;

  eth_rst_sync #(.STAGES(RST_STAGES)) u_rst_sync (
    .clk_i    (eth_rxc_sample),
    .arst_n_i (rst_n),
    .rst_n_o  (rst_int_n)
  );

  rx_state_e        state_q, state_d;
  logic             phase_q, phase_d;
  logic [3:0]       nib_q, nib_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [7:0]       rxd_q, rxd_d;
  logic             vld_q, vld_d, dv_q, dv_d, sof_q, sof_d;
  logic             eof_q, eof_d, err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;

  always_ff @(posedge eth_rxc_sample or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      nib_q     <= '0;
      pre_cnt_q <= '0;
      count_q   <= '0;
      rxd_q     <= '0;
      vld_q     <= 1'b0;
      dv_q      <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      nib_q     <= nib_d;
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      rxd_q     <= rxd_d;
      vld_q     <= vld_d;
      dv_q      <= dv_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
      len_q     <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    nib_d     = nib_q;
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    rxd_d     = rxd_q;
    vld_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = err_q;
    len_d     = len_q;
    // dv falls the cycle after eof even when the next nibble enable is far away
    dv_d      = eof_q ? 1'b0 : dv_q;

    if (rx_ce) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rgmii_rx_ctl) begin
            count_d = '0;
            if (ALIGN_MODE == ALIGN_LEGACY) begin
              state_d = ST_DATA;
              nib_d   = rgmii_rxd;
              phase_d = 1'b1;
            end else if (rgmii_rxd == PREAMBLE_NIBBLE) begin
              state_d   = ST_PRE;
              pre_cnt_d = PRE_W'(1);
            end else begin
              state_d = ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!rgmii_rx_ctl) begin
            state_d = ST_IDLE;
            eof_d   = 1'b1;
            err_d   = 1'b1;
            len_d   = '0;
          end else if (rgmii_rxd == PREAMBLE_NIBBLE) begin
            if (pre_cnt_q == PRE_MAX) begin
              state_d = ST_DROP;
            end else begin
              pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
          end else if (rgmii_rxd == SFD_NIBBLE && pre_cnt_q != '0) begin
            state_d = ST_DATA;
            phase_d = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
        ST_DATA: begin
          if (!rgmii_rx_ctl) begin
            state_d = ST_IDLE;
            eof_d   = 1'b1;
            err_d   = phase_q;
            len_d   = count_q;
            count_d = '0;
            phase_d = 1'b0;
          end else if (!phase_q) begin
            nib_d   = rgmii_rxd;
            phase_d = 1'b1;
          end else begin
            rxd_d   = pair_nibbles(nib_q, rgmii_rxd, NIBBLE_SWAP != 0);
            vld_d   = 1'b1;
            dv_d    = 1'b1;
            sof_d   = (count_q == '0);
            phase_d = 1'b0;
            if (count_q != '1) begin
              count_d = count_q + LEN_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (!rgmii_rx_ctl) begin
            state_d = ST_IDLE;
            eof_d   = 1'b1;
            err_d   = 1'b1;
            len_d   = count_q;
            count_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign gmii_rxd    = rxd_q;
  assign gmii_rx_vld = vld_q;
  assign gmii_rx_dv  = dv_q;
  assign gmii_rx_sof = sof_q;
  assign gmii_rx_eof = eof_q;
  assign gmii_rx_err = err_q;
  assign frame_len   = len_q;

endmodule

// File: tb/tb_rgmii_rx_nibble_framer.sv
// Bench for rgmii_rx_nibble_framer: three configurations share one nibble stream
// and are scored against a frame-level reference model.
module tb_rgmii_rx_nibble_framer;

  localparam int NDUT   = 3;
  localparam int MAXPRE = 16;
  localparam int RSTST  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_ce, rgmii_rx_ctl;
  logic [3:0] rgmii_rxd;

  logic [7:0]  oRxd [NDUT];
  logic        oVld [NDUT];
  logic        oDv  [NDUT];
  logic        oSof [NDUT];
  logic        oEof [NDUT];
  logic        oErr [NDUT];
  logic [15:0] oLen [NDUT];

  // dut 0: SFD align, low nibble first; dut 1: legacy pairing; dut 2: SFD align, swapped
  rgmii_rx_nibble_framer #(.ALIGN_MODE(1), .NIBBLE_SWAP(0), .MAX_PRE_NIBBLES(MAXPRE),
                           .LEN_W(16), .RST_STAGES(RSTST)) dutA (
    .eth_rxc_sample(clk), .rst_n(rst_n), .rx_ce(rx_ce), .rgmii_rx_ctl(rgmii_rx_ctl),
    .rgmii_rxd(rgmii_rxd), .gmii_rxd(oRxd[0]), .gmii_rx_vld(oVld[0]), .gmii_rx_dv(oDv[0]),
    .gmii_rx_sof(oSof[0]), .gmii_rx_eof(oEof[0]), .gmii_rx_err(oErr[0]), .frame_len(oLen[0]));

  rgmii_rx_nibble_framer #(.ALIGN_MODE(0), .NIBBLE_SWAP(0), .MAX_PRE_NIBBLES(MAXPRE),
                           .LEN_W(16), .RST_STAGES(RSTST)) dutB (
    .eth_rxc_sample(clk), .rst_n(rst_n), .rx_ce(rx_ce), .rgmii_rx_ctl(rgmii_rx_ctl),
    .rgmii_rxd(rgmii_rxd), .gmii_rxd(oRxd[1]), .gmii_rx_vld(oVld[1]), .gmii_rx_dv(oDv[1]),
    .gmii_rx_sof(oSof[1]), .gmii_rx_eof(oEof[1]), .gmii_rx_err(oErr[1]), .frame_len(oLen[1]));

  rgmii_rx_nibble_framer #(.ALIGN_MODE(1), .NIBBLE_SWAP(1), .MAX_PRE_NIBBLES(MAXPRE),
                           .LEN_W(16), .RST_STAGES(RSTST)) dutC (
    .eth_rxc_sample(clk), .rst_n(rst_n), .rx_ce(rx_ce), .rgmii_rx_ctl(rgmii_rx_ctl),
    .rgmii_rxd(rgmii_rxd), .gmii_rxd(oRxd[2]), .gmii_rx_vld(oVld[2]), .gmii_rx_dv(oDv[2]),
    .gmii_rx_sof(oSof[2]), .gmii_rx_eof(oEof[2]), .gmii_rx_err(oErr[2]), .frame_len(oLen[2]));

  int total = 0;
  int bad   = 0;

  logic [3:0] frameNibs [$];
  logic [7:0] expBytes  [NDUT][$];
  int         expLen    [NDUT][$];
  int         expErr    [NDUT][$];
  int         fb        [NDUT];
  int         vldCycles [$];
  int         cycleCount = 0;
  bit         ignoreScore = 0;
  int         cePeriod = 1;
  bit         randomCe = 0;

  typedef struct {
    string      name;
    int         preN;
    int         badPos;
    bit         sfd;
    int         dataN;
    logic [63:0] data;
    int         lenA;
    int         errA;
    int         lenB;
    int         errB;
  } vec_t;

  vec_t vecs [9];

  function automatic bit alignOf(input int d);
    return d != 1;
  endfunction

  function automatic bit swapOf(input int d);
    return d == 2;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  // Frame-level reference: find where payload begins, then pair what follows.
  task automatic modelFrame(input int d);
    int n, start, nPre, nd;
    logic [3:0] lo, hi;
    n = frameNibs.size();
    start = 0;
    if (alignOf(d)) begin
      nPre = 0;
      while (nPre < n && frameNibs[nPre] == 4'h5) nPre++;
      if (nPre >= 1 && nPre <= MAXPRE && nPre < n && frameNibs[nPre] == 4'hD) begin
        start = nPre + 1;
      end else begin
        expLen[d].push_back(0);
        expErr[d].push_back(1);
        return;
      end
    end
    nd = n - start;
    for (int k = 0; k < nd / 2; k++) begin
      lo = frameNibs[start + 2 * k];
      hi = frameNibs[start + 2 * k + 1];
      expBytes[d].push_back(swapOf(d) ? {lo, hi} : {hi, lo});
    end
    expLen[d].push_back(nd / 2);
    expErr[d].push_back(nd % 2);
  endtask

  task automatic queueModel();
    for (int d = 0; d < NDUT; d++) modelFrame(d);
  endtask

  task automatic buildFrame(input int preN, input int badPos, input bit sfd,
                            input int dataN, input logic [63:0] data);
    frameNibs.delete();
    for (int i = 0; i < preN; i++) frameNibs.push_back(i == badPos ? 4'h7 : 4'h5);
    if (sfd) frameNibs.push_back(4'hD);
    for (int i = 0; i < dataN; i++) frameNibs.push_back(data[i*4 +: 4]);
  endtask

  task automatic applyStimulus(input logic ctl, input logic [3:0] nib);
    int gaps;
    gaps = randomCe ? int'($urandom_range(0, 3)) : cePeriod - 1;
    for (int i = 0; i < gaps; i++) begin
      @(negedge clk);
      rx_ce        = 1'b0;
      rgmii_rx_ctl = 1'($urandom);
      rgmii_rxd    = 4'($urandom);
    end
    @(negedge clk);
    rx_ce        = 1'b1;
    rgmii_rx_ctl = ctl;
    rgmii_rxd    = nib;
  endtask

  task automatic driveFrame();
    foreach (frameNibs[i]) applyStimulus(1'b1, frameNibs[i]);
    applyStimulus(1'b0, 4'($urandom));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_ce        = 1'($urandom);
      rgmii_rx_ctl = 1'b0;
      rgmii_rxd    = 4'($urandom);
    end
  endtask

  task automatic checkZero(input string name);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s_d%0d", name, d),
                  int'({oRxd[d], oVld[d], oDv[d], oSof[d], oEof[d], oErr[d], oLen[d]}), 0);
    end
  endtask

  // Scoreboard: bytes, sof/dv framing and eof results for every instance.
  always @(posedge clk) begin
    #1;
    cycleCount++;
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n || ignoreScore) begin
        fb[d] = 0;
        continue;
      end
      if (oVld[d]) begin
        if (oEof[d]) checkOutput($sformatf("vld_with_eof_d%0d", d), 1, 0);
        checkOutput($sformatf("sof_d%0d", d), int'(oSof[d]), int'(fb[d] == 0));
        if (expBytes[d].size() == 0) begin
          checkOutput($sformatf("extra_byte_d%0d", d), int'(oRxd[d]), -1);
        end else begin
          checkOutput($sformatf("byte_d%0d", d), int'(oRxd[d]), int'(expBytes[d].pop_front()));
        end
        fb[d]++;
        if (d == 1) vldCycles.push_back(cycleCount);
      end else if (oSof[d]) begin
        checkOutput($sformatf("sof_no_vld_d%0d", d), 1, 0);
      end
      checkOutput($sformatf("dv_d%0d", d), int'(oDv[d]), int'(fb[d] > 0));
      if (oEof[d]) begin
        if (expLen[d].size() == 0) begin
          checkOutput($sformatf("extra_eof_d%0d", d), 1, 0);
        end else begin
          checkOutput($sformatf("len_d%0d", d), int'(oLen[d]), expLen[d][0]);
          checkOutput($sformatf("nbytes_d%0d", d), fb[d], expLen[d].pop_front());
          checkOutput($sformatf("err_d%0d", d), int'(oErr[d]), expErr[d].pop_front());
        end
        fb[d] = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   preN, kind, nDat;

    vecs[0] = '{"clean",    15, -1, 1, 4, 64'h1234,     2, 0, 10, 0};
    vecs[1] = '{"odd",      15, -1, 1, 5, 64'h51234,    2, 1, 10, 1};
    vecs[2] = '{"bad_pre",  15,  3, 1, 4, 64'h1234,     0, 1, 10, 0};
    vecs[3] = '{"clean2",    7, -1, 1, 8, 64'h89abcdef, 4, 0,  8, 0};
    vecs[4] = '{"overrun",  20, -1, 1, 4, 64'h1234,     0, 1, 12, 1};
    vecs[5] = '{"max_pre",  16, -1, 1, 2, 64'h9e,       1, 0,  9, 1};
    vecs[6] = '{"no_sfd",    6, -1, 0, 0, 64'h0,        0, 1,  3, 0};
    vecs[7] = '{"min_pre",   1, -1, 1, 2, 64'hc3,       1, 0,  2, 0};
    vecs[8] = '{"sfd_first", 0, -1, 1, 2, 64'h21,       0, 1,  1, 1};

    rst_n        = 1'b0;
    rx_ce        = 1'b0;
    rgmii_rx_ctl = 1'b0;
    rgmii_rxd    = 4'h0;
    #1;
    checkZero("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(RSTST + 2);
    checkZero("post_release_idle");

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      v = vecs[i];
      buildFrame(v.preN, v.badPos, v.sfd, v.dataN, v.data);
      queueModel();
      for (int d = 0; d < NDUT; d++) begin
        expLen[d][expLen[d].size() - 1] = (d == 1) ? v.lenB : v.lenA;
        expErr[d][expErr[d].size() - 1] = (d == 1) ? v.errB : v.errA;
      end
      driveFrame();
      idleCycles(i % 3);
    end
    idleCycles(3);

    $display("[TB] 10M enable, 64 nibbles");
    vldCycles.delete();
    cePeriod = 10;
    frameNibs.delete();
    for (int i = 0; i < 64; i++) frameNibs.push_back(4'($urandom));
    queueModel();
    driveFrame();
    cePeriod = 1;
    idleCycles(4);
    checkOutput("ce10_strobes", vldCycles.size(), 32);
    for (int i = 1; i < vldCycles.size(); i++) begin
      checkOutput($sformatf("ce10_gap%0d", i), vldCycles[i] - vldCycles[i-1], 20);
    end

    $display("[TB] reset mid-frame");
    ignoreScore = 1;
    buildFrame(7, -1, 1, 3, 64'h234);
    foreach (frameNibs[i]) applyStimulus(1'b1, frameNibs[i]);
    @(negedge clk);
    rx_ce = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_dv", int'(oDv[0]), 1);
    checkOutput("pre_rst_byte_d0", int'(oRxd[0]), 8'h34);
    checkOutput("pre_rst_byte_d1", int'(oRxd[1]), 8'h34);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("async_rst");
    ignoreScore = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_ce        = 1'b1;
      rgmii_rx_ctl = 1'b1;
      rgmii_rxd    = 4'($urandom);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    rx_ce        = 1'b1;
    rgmii_rx_ctl = 1'b1;
    rgmii_rxd    = 4'hD;
    for (int k = 0; k < RSTST - 1; k++) begin
      @(negedge clk);
      checkZero($sformatf("rst_sync%0d", k));
      rgmii_rxd = 4'hD;
    end
    buildFrame(1, -1, 1, 4, 64'h1234);
    queueModel();
    driveFrame();
    idleCycles(3);

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      randomCe = f[0];
      kind = $urandom_range(0, 9);
      preN = (kind == 2) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 16));
      nDat = $urandom_range(0, 12);
      buildFrame(preN, (kind == 0) ? int'($urandom_range(0, 16)) : -1, kind != 1, nDat,
                 {$urandom, $urandom});
      if (frameNibs.size() == 0) frameNibs.push_back(4'h5);
      queueModel();
      driveFrame();
      if (kind > 5) idleCycles($urandom_range(0, 4));
    end
    randomCe = 0;
    idleCycles(6);

    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("pending_eof_d%0d", d), expLen[d].size(), 0);
      checkOutput($sformatf("pending_bytes_d%0d", d), expBytes[d].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
